dump_ctrl: RTL and testbench

Sequences a channel dump for the capture front end. On a `dump` pulse it reads the channel's offset and gain calibration bytes from the calibration EEPROM over the shared SPI master and loads them into the gain-correction registers. It then walks the 512-entry capture RAM from oldest to newest sample and hands each corrected byte to the UART response path with a send/sent handshake. It owns the SPI master, RAM read port and response path only while `busy` is high; the command decoder stays idle during that time.

---
 rtl/dump_ctrl_pkg.sv | 46 ++++
 rtl/dump_ctrl_if.sv | 44 ++++
 rtl/dump_ctrl_eep_cal_reader.sv | 57 +++++
 rtl/dump_ctrl.sv | 169 ++++++++++++++++
 tb/tb_dump_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dump_ctrl_pkg.sv
// dump_ctrl_pkg
// Shared types and constants for the channel dump controller and the
// command decoder's EEPROM read path.
//   dump_state_t  - dump sequencer states
//   eep_phase_t   - phase of a two-frame EEPROM read
//   SS_EEP        - slave select value for the calibration EEPROM
//   EEP_DUMMY     - dummy frame clocked out to read back the EEPROM byte
//   RESP_NAK      - response byte for a rejected dump request
//   eep_addr()    - packs channel, AFE gain and byte select into an EEPROM address
package dump_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ERR,
    ST_OFF_CMD,
    ST_OFF_WAIT,
    ST_OFF_RD,
    ST_GAIN_CMD,
    ST_GAIN_WAIT,
    ST_GAIN_RD,
    ST_RD,
    ST_LAT,
    ST_SEND,
    ST_WAIT,
    ST_DONE
  } dump_state_t;

  typedef enum logic [1:0] {
    EP_IDLE,
    EP_CMD,
    EP_WAIT,
    EP_RD
  } eep_phase_t;

  localparam logic [2:0]  SS_EEP    = 3'b100;
  localparam logic [15:0] EEP_DUMMY = 16'hBCBC;
  localparam logic [7:0]  RESP_NAK  = 8'hEE;

  // sel=0 addresses the offset byte, sel=1 the gain byte
  function automatic logic [5:0] eep_addr(input logic [1:0] ch,
                                          input logic [2:0] g,
                                          input logic       sel);
    return {ch, g, sel};
  endfunction

endpackage

// File: rtl/dump_ctrl_if.sv
// dump_ctrl_if
// Signals between the dump controller and its environment: command
// decoder (dump/dump_ch/clr_cmd_rdy), AFE gain settings, SPI master,
// calibration register loads, capture RAM read port and UART response path.
//   master - dump controller side
//   slave  - environment side
interface dump_ctrl_if #(parameter int DEPTH_LOG2 = 9);
  logic                  dump;
  logic [1:0]            dump_ch;
  logic [2:0]            ch1_AFEgain;
  logic [2:0]            ch2_AFEgain;
  logic [2:0]            ch3_AFEgain;
  logic [DEPTH_LOG2-1:0] end_addr;
  logic                  SPI_done;
  logic [7:0]            EEP_data;
  logic [7:0]            corrected_data;
  logic                  resp_sent;

  logic                  busy;
  logic                  wrt_SPI;
  logic [15:0]           SPI_data;
  logic [2:0]            ss;
  logic                  flopOffset;
  logic                  flopGain;
  logic                  ren;
  logic [DEPTH_LOG2-1:0] raddr;
  logic                  send_resp;
  logic [7:0]            resp_data;
  logic                  clr_cmd_rdy;

  modport master (
    input  dump, dump_ch, ch1_AFEgain, ch2_AFEgain, ch3_AFEgain, end_addr,
           SPI_done, EEP_data, corrected_data, resp_sent,
    output busy, wrt_SPI, SPI_data, ss, flopOffset, flopGain, ren, raddr,
           send_resp, resp_data, clr_cmd_rdy
  );

  modport slave (
    output dump, dump_ch, ch1_AFEgain, ch2_AFEgain, ch3_AFEgain, end_addr,
           SPI_done, EEP_data, corrected_data, resp_sent,
    input  busy, wrt_SPI, SPI_data, ss, flopOffset, flopGain, ren, raddr,
           send_resp, resp_data, clr_cmd_rdy
  );
endinterface

// File: rtl/dump_ctrl_eep_cal_reader.sv
// eep_cal_reader
// Frame generator for a two-frame calibration EEPROM read: an address
// frame followed by a dummy frame whose return carries the data byte.
// The caller steps the phase; this block decides the SPI frame contents.
//   phase    in  current read phase (idle/cmd/wait/rd)
//   addr     in  6-bit EEPROM address
//   spi_done in  SPI transaction complete
//   wrt_spi  out start SPI frame (one cycle)
//   spi_data out SPI transmit word, held through the wait phases
//   ss       out slave select
//   rd_done  out data byte is on EEP_data this cycle (one cycle)
module eep_cal_reader
  import dump_ctrl_pkg::*;
(
  input  eep_phase_t  phase,
  input  logic [5:0]  addr,
  input  logic        spi_done,
  output logic        wrt_spi,
  output logic [15:0] spi_data,
  output logic [2:0]  ss,
  output logic        rd_done
);

  logic [15:0] cmd_word;
  assign cmd_word = {2'b00, addr, 8'h00};

  always_comb begin
    wrt_spi  = 1'b0;
    spi_data = '0;
    ss       = '0;
    rd_done  = 1'b0;
    case (phase)
      EP_CMD: begin
        wrt_spi  = 1'b1;
        ss       = SS_EEP;
        spi_data = cmd_word;
      end
      EP_WAIT: begin
        ss = SS_EEP;
        // address frame finished: launch the dummy frame in the same cycle
        if (spi_done) begin
          wrt_spi  = 1'b1;
          spi_data = EEP_DUMMY;
        end else begin
          spi_data = cmd_word;
        end
      end
      EP_RD: begin
        ss       = SS_EEP;
        spi_data = EEP_DUMMY;
        rd_done  = spi_done;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dump_ctrl.sv
// dump_ctrl
// Channel dump sequencer: reads the channel's offset and gain calibration
// bytes from EEPROM, then streams every capture RAM sample (oldest first)
// through the corrector to the UART response path.
//   clk  in  system clock
//   rst  in  synchronous active-high reset
//   bus  dump_ctrl_if.master - command, SPI, RAM and response signals
//
// state     | meaning
// IDLE      | waiting for dump
// ERR       | reserved channel: send NAK byte, wait for resp_sent
// OFF_CMD   | launch offset address frame
// OFF_WAIT  | wait address frame, then launch dummy frame
// OFF_RD    | wait dummy frame, load offset register
// GAIN_CMD  | launch gain address frame
// GAIN_WAIT | wait address frame, then launch dummy frame
// GAIN_RD   | wait dummy frame, load gain register
// RD        | RAM read at ptr
// LAT       | RAM data settles through corrector
// SEND      | request UART send of corrected byte
// WAIT      | wait resp_sent, advance or finish
// DONE      | retire command
module dump_ctrl
  import dump_ctrl_pkg::*;
#(
  parameter int DEPTH_LOG2 = 9
)(
  input  logic       clk,
  input  logic       rst,
  dump_ctrl_if.master bus
);

  localparam logic [DEPTH_LOG2-1:0] CNT_LAST = '1;

  dump_state_t           state, state_nxt;
  logic [1:0]            ch;
  logic [2:0]            g;
  logic [DEPTH_LOG2-1:0] ptr;
  logic [DEPTH_LOG2-1:0] cnt;
  logic [7:0]            resp_q;
  logic                  err_first;
  logic                  busy_q;
  logic [2:0]            gain_sel;
  eep_phase_t            eep_phase;
  logic                  eep_sel;
  logic [5:0]            eep_a;
  logic                  eep_rd_done;

  always_comb begin
    gain_sel = '0;
    case (bus.dump_ch)
      2'b00:   gain_sel = bus.ch1_AFEgain;
      2'b01:   gain_sel = bus.ch2_AFEgain;
      2'b10:   gain_sel = bus.ch3_AFEgain;
      default: gain_sel = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      busy_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy_q <= (state_nxt != ST_IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch        <= '0;
      g         <= '0;
      ptr       <= '0;
      cnt       <= '0;
      resp_q    <= '0;
      err_first <= 1'b0;
    end else begin
      err_first <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.dump) begin
            ch <= bus.dump_ch;
            g  <= gain_sel;
            if (bus.dump_ch == 2'b11) begin
              err_first <= 1'b1;
            end else begin
              // oldest sample sits just past the last written address
              ptr <= bus.end_addr + 1'b1;
              cnt <= '0;
            end
          end
        end
        ST_SEND: resp_q <= bus.corrected_data;
        ST_WAIT: begin
          if (bus.resp_sent && cnt != CNT_LAST) begin
            ptr <= ptr + 1'b1;
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (bus.dump) state_nxt = (bus.dump_ch == 2'b11) ? ST_ERR : ST_OFF_CMD;
      ST_ERR:       if (bus.resp_sent && !err_first) state_nxt = ST_DONE;
      ST_OFF_CMD:   state_nxt = ST_OFF_WAIT;
      ST_OFF_WAIT:  if (bus.SPI_done) state_nxt = ST_OFF_RD;
      ST_OFF_RD:    if (bus.SPI_done) state_nxt = ST_GAIN_CMD;
      ST_GAIN_CMD:  state_nxt = ST_GAIN_WAIT;
      ST_GAIN_WAIT: if (bus.SPI_done) state_nxt = ST_GAIN_RD;
      ST_GAIN_RD:   if (bus.SPI_done) state_nxt = ST_RD;
      ST_RD:        state_nxt = ST_LAT;
      ST_LAT:       state_nxt = ST_SEND;
      ST_SEND:      state_nxt = ST_WAIT;
      ST_WAIT:      if (bus.resp_sent) state_nxt = (cnt == CNT_LAST) ? ST_DONE : ST_RD;
      ST_DONE:      state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    eep_phase = EP_IDLE;
    eep_sel   = 1'b0;
    case (state)
      ST_OFF_CMD:   eep_phase = EP_CMD;
      ST_OFF_WAIT:  eep_phase = EP_WAIT;
      ST_OFF_RD:    eep_phase = EP_RD;
      ST_GAIN_CMD:  begin eep_phase = EP_CMD;  eep_sel = 1'b1; end
      ST_GAIN_WAIT: begin eep_phase = EP_WAIT; eep_sel = 1'b1; end
      ST_GAIN_RD:   begin eep_phase = EP_RD;   eep_sel = 1'b1; end
      default: ;
    endcase
  end

  assign eep_a = eep_addr(ch, g, eep_sel);

  // one reader shared by the offset and gain reads; eep_sel picks the byte
  eep_cal_reader u_eep (
    .phase    (eep_phase),
    .addr     (eep_a),
    .spi_done (bus.SPI_done),
    .wrt_spi  (bus.wrt_SPI),
    .spi_data (bus.SPI_data),
    .ss       (bus.ss),
    .rd_done  (eep_rd_done)
  );

  always_comb begin
    bus.busy        = busy_q;
    bus.flopOffset  = eep_rd_done & ~eep_sel;
    bus.flopGain    = eep_rd_done & eep_sel;
    bus.ren         = (state == ST_RD);
    bus.raddr       = (state == ST_RD) ? ptr : '0;
    bus.send_resp   = (state == ST_SEND) || (state == ST_ERR && err_first);
    bus.clr_cmd_rdy = (state == ST_DONE);
    bus.resp_data   = '0;
    case (state)
      ST_SEND: bus.resp_data = bus.corrected_data;
      ST_WAIT: bus.resp_data = resp_q;
      ST_ERR:  bus.resp_data = RESP_NAK;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dump_ctrl.sv
// tb_dump_ctrl
// Self-checking bench for dump_ctrl: SPI/EEPROM, capture RAM, corrector and
// UART responders with randomized data and latencies; expected bytes and
// addresses come from a sample-order model of the capture RAM.
module tb_dump_ctrl;

  localparam int DL = 9;
  localparam int N  = 512;

  logic clk;
  logic rst;

  dump_ctrl_if #(.DEPTH_LOG2(DL)) bus ();

  dump_ctrl #(.DEPTH_LOG2(DL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]    ram [N];
  logic [7:0]    ram_rdata;
  logic          rd_pend;
  logic [DL-1:0] rd_addr;
  int spi_timer, resp_timer, resp_delay, cyc;

  logic [7:0]  got_bytes[$];
  logic [7:0]  got_corr[$];
  int          got_raddr[$];
  logic [15:0] got_spi[$];
  logic [15:0] last_spi;
  int n_wrt, n_ren, n_send, n_clr, n_off, n_gain, bad_ss, proto_err, spi_unstable;
  int dump_cyc, first_wrt_cyc, off_cyc, gain_cyc, clr_cyc, resp_sent_cyc;
  int first_ren_cyc, last_ren_cyc;
  logic busy_first_wrt, busy_at_clr;

  // bench-side corrector standing in for the gain/offset datapath
  function automatic logic [7:0] corr(input logic [7:0] b);
    return b * 8'd3 + 8'd7;
  endfunction

  function automatic int exp_addr(input logic [DL-1:0] ea, input int i);
    return (int'(ea) + 1 + i) % N;
  endfunction

  function automatic logic [15:0] spi_cmd(input logic [1:0] c, input logic [2:0] gg, input logic sel);
    return {2'b00, c, gg, sel, 8'h00};
  endfunction

  function automatic logic [42:0] outs();
    return {bus.busy, bus.wrt_SPI, bus.SPI_data, bus.ss, bus.flopOffset, bus.flopGain,
            bus.ren, bus.raddr, bus.send_resp, bus.resp_data, bus.clr_cmd_rdy};
  endfunction

  task automatic clear_logs();
    got_bytes.delete(); got_corr.delete(); got_raddr.delete(); got_spi.delete();
    n_wrt = 0; n_ren = 0; n_send = 0; n_clr = 0; n_off = 0; n_gain = 0;
    bad_ss = 0; proto_err = 0; spi_unstable = 0;
    dump_cyc = -1; first_wrt_cyc = -1; off_cyc = -1; gain_cyc = -1; clr_cyc = -1;
    resp_sent_cyc = -1; first_ren_cyc = -1; last_ren_cyc = -1;
    busy_first_wrt = 1'b0; busy_at_clr = 1'b0;
  endtask

  // responders drive at negedge, then sample DUT outputs 1 time unit later
  initial begin
    bus.SPI_done = 1'b0; bus.resp_sent = 1'b0; bus.EEP_data = '0; bus.corrected_data = '0;
    ram_rdata = '0; rd_pend = 1'b0; rd_addr = '0;
    spi_timer = 0; resp_timer = 0; cyc = 0;
    forever begin
      @(negedge clk);
      bus.SPI_done = (spi_timer == 1);
      if (spi_timer > 0) spi_timer--;
      if (bus.SPI_done) bus.EEP_data = 8'($urandom);
      bus.resp_sent = (resp_timer == 1);
      if (resp_timer > 0) resp_timer--;
      if (rd_pend) ram_rdata = ram[rd_addr];
      rd_pend = 1'b0;
      bus.corrected_data = corr(ram_rdata);
      #1;
      cyc++;
      if (bus.dump && !bus.busy) dump_cyc = cyc;
      if (bus.resp_sent) resp_sent_cyc = cyc;
      if (bus.wrt_SPI) begin
        if (spi_timer > 0) proto_err++;
        if (bus.ss !== 3'b100) bad_ss++;
        if (n_wrt == 0) begin first_wrt_cyc = cyc; busy_first_wrt = bus.busy; end
        n_wrt++;
        got_spi.push_back(bus.SPI_data);
        last_spi = bus.SPI_data;
        spi_timer = $urandom_range(1, 4);
      end else if (spi_timer > 0) begin
        if (bus.SPI_data !== last_spi) spi_unstable++;
        if (bus.ss !== 3'b100) bad_ss++;
      end
      if (bus.ren) begin
        if (n_ren == 0) first_ren_cyc = cyc;
        last_ren_cyc = cyc;
        n_ren++;
        got_raddr.push_back(int'(bus.raddr));
        rd_pend = 1'b1;
        rd_addr = bus.raddr;
      end
      if (bus.send_resp) begin
        if (resp_timer > 0) proto_err++;
        n_send++;
        got_bytes.push_back(bus.resp_data);
        got_corr.push_back(bus.corrected_data);
        resp_timer = resp_delay;
      end
      if (bus.flopOffset) begin n_off++; off_cyc = cyc; end
      if (bus.flopGain) begin n_gain++; gain_cyc = cyc; end
      if (bus.clr_cmd_rdy) begin n_clr++; clr_cyc = cyc; busy_at_clr = bus.busy; end
    end
  end

  task automatic run_dump(input logic [1:0] c, input logic [DL-1:0] ea, input int rdelay,
                          input int inject_at);
    bit injected;
    injected = 1'b0;
    resp_delay = rdelay;
    @(negedge clk);
    clear_logs();
    bus.dump_ch = c; bus.end_addr = ea; bus.dump = 1'b1;
    @(negedge clk);
    bus.dump = 1'b0;
    for (int i = 0; i < 20000 && n_clr == 0; i++) begin
      @(negedge clk);
      if (inject_at >= 0 && n_send == inject_at && !injected) begin
        bus.dump = 1'b1; bus.dump_ch = 2'((c + 2'd1) % 3); injected = 1'b1;
      end else begin
        bus.dump = 1'b0; bus.dump_ch = c;
      end
    end
    n_checks++;
    if (n_clr == 0) begin
      $display("FAIL dump_timeout: clr_cmd_rdy count %0d, required 1", n_clr);
      n_fail++;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    n_checks++;
    if (outs() !== '0) begin
      $display("FAIL reset_outputs: got %0h required 0", outs()); n_fail++;
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk); #2;
    n_checks++;
    if (outs() !== '0 || bus.busy !== 1'b0) begin
      $display("FAIL idle_after_reset: got %0h required 0", outs()); n_fail++;
    end
  endtask

  task automatic test_ch1_full();
    logic [15:0] exp_w [4];
    int bad;
    bus.ch1_AFEgain = 3'b011;
    run_dump(2'b00, 9'h1FF, 1, -1);
    exp_w[0] = spi_cmd(2'b00, 3'b011, 1'b0); exp_w[1] = 16'hBCBC;
    exp_w[2] = spi_cmd(2'b00, 3'b011, 1'b1); exp_w[3] = 16'hBCBC;
    n_checks++;
    if (got_spi.size() != 4) begin
      $display("FAIL ch1_spi_count: got %0d required 4", got_spi.size()); n_fail++;
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (got_spi[i] !== exp_w[i]) begin
          $display("FAIL ch1_spi_word%0d: got %h required %h", i, got_spi[i], exp_w[i]); n_fail++;
        end
      end
    end
    n_checks++;
    if (bad_ss != 0 || spi_unstable != 0) begin
      $display("FAIL ch1_ss_hold: bad_ss %0d unstable %0d required 0 0", bad_ss, spi_unstable); n_fail++;
    end
    n_checks++;
    if (n_off != 1 || n_gain != 1 || off_cyc >= gain_cyc) begin
      $display("FAIL ch1_flops: off %0d@%0d gain %0d@%0d required 1 then 1", n_off, off_cyc, n_gain, gain_cyc); n_fail++;
    end
    n_checks++;
    if (n_ren != N || got_raddr.size() != N || got_raddr[0] != 0 || got_raddr[N-1] != 511) begin
      $display("FAIL ch1_raddr_ends: reads %0d first %0d last %0d required 512 0 511",
               n_ren, got_raddr.size() > 0 ? got_raddr[0] : -1, got_raddr.size() > 0 ? got_raddr[got_raddr.size()-1] : -1);
      n_fail++;
    end
    bad = 0;
    for (int i = 0; i < got_bytes.size() && i < N; i++)
      if (got_bytes[i] !== corr(ram[exp_addr(9'h1FF, i)])) bad++;
    n_checks++;
    if (n_send != N || bad != 0) begin
      $display("FAIL ch1_bytes: sends %0d bad %0d required 512 0", n_send, bad); n_fail++;
    end
    n_checks++;
    if (n_clr != 1 || busy_at_clr !== 1'b1 || bus.busy !== 1'b0) begin
      $display("FAIL ch1_done: clr %0d busy_at_clr %0b busy_now %0b required 1 1 0", n_clr, busy_at_clr, bus.busy); n_fail++;
    end
    n_checks++;
    if (first_wrt_cyc != dump_cyc + 1 || busy_first_wrt !== 1'b1) begin
      $display("FAIL start_latency: wrt at %0d dump at %0d busy %0b required +1 busy 1", first_wrt_cyc, dump_cyc, busy_first_wrt); n_fail++;
    end
    n_checks++;
    if (last_ren_cyc - first_ren_cyc != (N - 1) * 4 || proto_err != 0) begin
      $display("FAIL sample_period: span %0d proto %0d required %0d 0", last_ren_cyc - first_ren_cyc, proto_err, (N - 1) * 4); n_fail++;
    end
  endtask

  task automatic test_wrap();
    int bad;
    logic [2:0] gg;
    gg = 3'($urandom_range(0, 7));
    bus.ch2_AFEgain = gg;
    bus.ch1_AFEgain = ~gg;
    run_dump(2'b01, 9'h0FF, 1, -1);
    n_checks++;
    if (got_spi.size() < 3 || got_spi[0] !== spi_cmd(2'b01, gg, 1'b0) || got_spi[2] !== spi_cmd(2'b01, gg, 1'b1)) begin
      $display("FAIL wrap_spi_addr: got %h required %h", got_spi.size() > 0 ? got_spi[0] : 16'h0, spi_cmd(2'b01, gg, 1'b0)); n_fail++;
    end
    bad = 0;
    for (int i = 0; i < got_raddr.size() && i < N; i++)
      if (got_raddr[i] != exp_addr(9'h0FF, i)) bad++;
    n_checks++;
    if (got_raddr.size() != N || bad != 0 || got_raddr[0] != 'h100) begin
      $display("FAIL wrap_raddr_seq: reads %0d bad %0d required 512 0", got_raddr.size(), bad); n_fail++;
    end
    bad = 0;
    for (int i = 0; i < got_bytes.size() && i < N; i++)
      if (got_bytes[i] !== corr(ram[exp_addr(9'h0FF, i)])) bad++;
    n_checks++;
    if (n_send != N || bad != 0) begin
      $display("FAIL wrap_bytes: sends %0d bad %0d required 512 0", n_send, bad); n_fail++;
    end
  endtask

  task automatic test_err();
    run_dump(2'b11, 9'($urandom), 3, -1);
    n_checks++;
    if (n_send != 1 || got_bytes.size() != 1 || got_bytes[0] !== 8'hEE) begin
      $display("FAIL err_nak: sends %0d byte %h required 1 ee", n_send, got_bytes.size() > 0 ? got_bytes[0] : 8'h0); n_fail++;
    end
    n_checks++;
    if (n_wrt != 0 || n_ren != 0 || n_off != 0 || n_gain != 0) begin
      $display("FAIL err_no_activity: wrt %0d ren %0d required 0 0", n_wrt, n_ren); n_fail++;
    end
    n_checks++;
    if (n_clr != 1 || resp_sent_cyc < 0 || clr_cyc <= resp_sent_cyc) begin
      $display("FAIL err_clr: clr %0d at %0d resp_sent at %0d required 1 after", n_clr, clr_cyc, resp_sent_cyc); n_fail++;
    end
  endtask

  task automatic test_slow_resp();
    int bad, mism;
    logic [DL-1:0] ea;
    ea = 9'($urandom);
    bus.ch3_AFEgain = 3'($urandom_range(0, 7));
    run_dump(2'b10, ea, 10, -1);
    bad = 0; mism = 0;
    for (int i = 0; i < got_bytes.size() && i < N; i++) begin
      if (got_bytes[i] !== corr(ram[exp_addr(ea, i)])) bad++;
      if (got_bytes[i] !== got_corr[i]) mism++;
    end
    n_checks++;
    if (n_send != N || proto_err != 0) begin
      $display("FAIL slow_send_count: sends %0d proto %0d required 512 0", n_send, proto_err); n_fail++;
    end
    n_checks++;
    if (bad != 0 || mism != 0) begin
      $display("FAIL slow_bytes: bad %0d vs_corrected %0d required 0 0", bad, mism); n_fail++;
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    logic [DL-1:0] ea;
    ea = 9'($urandom);
    resp_delay = 1;
    @(negedge clk);
    clear_logs();
    bus.dump_ch = 2'b00; bus.end_addr = ea; bus.dump = 1'b1;
    @(negedge clk);
    bus.dump = 1'b0;
    for (int i = 0; i < 5000 && n_send < 100; i++) @(negedge clk);
    n_checks++;
    if (n_send != 100) begin
      $display("FAIL rst_mid_reach: sends %0d required 100", n_send); n_fail++;
    end
    rst = 1'b1;
    #2;
    spi_timer = 0; resp_timer = 0;
    @(negedge clk); #2;
    n_checks++;
    if (outs() !== '0 || bus.busy !== 1'b0) begin
      $display("FAIL rst_mid_outputs: got %0h required 0", outs()); n_fail++;
    end
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (n_clr != 0) begin
      $display("FAIL rst_mid_no_clr: clr %0d required 0", n_clr); n_fail++;
    end
    run_dump(2'b00, ea, 1, -1);
    n_checks++;
    if (got_spi.size() == 0 || got_spi[0] !== spi_cmd(2'b00, bus.ch1_AFEgain, 1'b0)) begin
      $display("FAIL rst_restart_offset: got %h required %h", got_spi.size() > 0 ? got_spi[0] : 16'h0, spi_cmd(2'b00, bus.ch1_AFEgain, 1'b0)); n_fail++;
    end
    bad = 0;
    for (int i = 0; i < got_bytes.size() && i < N; i++)
      if (got_bytes[i] !== corr(ram[exp_addr(ea, i)])) bad++;
    n_checks++;
    if (n_send != N || bad != 0) begin
      $display("FAIL rst_restart_bytes: sends %0d bad %0d required 512 0", n_send, bad); n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    int bad;
    logic [DL-1:0] ea;
    ea = 9'($urandom);
    run_dump(2'b01, ea, 1, 50);
    bad = 0;
    for (int i = 0; i < got_bytes.size() && i < N; i++)
      if (got_bytes[i] !== corr(ram[exp_addr(ea, i)])) bad++;
    n_checks++;
    if (n_send != N || n_clr != 1 || bad != 0 || n_wrt != 4) begin
      $display("FAIL mid_dump_ignored: sends %0d clr %0d bad %0d wrt %0d required 512 1 0 4", n_send, n_clr, bad, n_wrt); n_fail++;
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.dump = 1'b0; bus.dump_ch = '0; bus.end_addr = '0;
    bus.ch1_AFEgain = '0; bus.ch2_AFEgain = '0; bus.ch3_AFEgain = '0;
    resp_delay = 1;
    for (int i = 0; i < N; i++) ram[i] = 8'($urandom);
    clear_logs();
    test_reset();
    test_ch1_full();
    test_wrap();
    test_err();
    test_slow_resp();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
